// File: rtl/conv_encoder_pkg.sv
// Shared convolutional code definition: default code parameters, FSM state
// type and a reference symbol function for the encoder and decoder sides.
package conv_encoder_pkg;

    localparam int CONV_R      = 2;
    localparam int CONV_K      = 3;
    localparam int CONV_LENOUT = 5;
    localparam int CONV_LENIN  = CONV_LENOUT * CONV_R;

    localparam logic [CONV_K-1:0] CONV_G0 = 3'b111;
    localparam logic [CONV_K-1:0] CONV_G1 = 3'b101;

    localparam logic [CONV_R-1:0] MASKCODE  = '1;
    localparam logic [CONV_K-2:0] MASKSTATE = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_DONE
    } enc_state_t;

    // Symbol produced from shift state `state` with input bit `bit_in`
    function automatic logic [CONV_R-1:0] conv_symbol(input logic [CONV_K-2:0] state,
                                                      input logic              bit_in);
        logic [CONV_K-1:0] w;
        logic [CONV_R-1:0] sym;
        w           = {bit_in, state & MASKSTATE};
        sym         = '0;
        sym[CONV_R-1] = ^(w & CONV_G0);
        sym[0]        = ^(w & CONV_G1);
        return sym & MASKCODE;
    endfunction

endpackage

// File: rtl/conv_sym_gen.sv
// Combinational symbol generator: window {u, sr} -> r-bit symbol.
// G0 drives the symbol MSB, G1 drives bit 0.
import conv_encoder_pkg::*;

module conv_sym_gen #(
    parameter int             r  = CONV_R,
    parameter int             K  = CONV_K,
    parameter logic [K-1:0]   G0 = CONV_G0,
    parameter logic [K-1:0]   G1 = CONV_G1
) (
    input  logic [K-1:0] w,
    output logic [r-1:0] sym
);

    // Parity of the tapped window bits for each generator
    always_comb begin
        sym      = '0;
        sym[r-1] = ^(w & G0);
        sym[0]   = ^(w & G1);
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/r convolutional encoder: encodes one message bit per clock,
// streams each symbol, then presents the packed codeword with a done pulse.
// Also exports the constant trellis output table for the decoder.
import conv_encoder_pkg::*;

module conv_encoder #(
    parameter int           r      = CONV_R,
    parameter int           K      = CONV_K,
    parameter int           lenout = CONV_LENOUT,
    parameter int           lenin  = CONV_LENIN,
    parameter logic [K-1:0] G0     = CONV_G0,
    parameter logic [K-1:0] G1     = CONV_G1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [lenout-1:0]           msg_in,
    output logic                        busy,
    output logic                        sym_valid,
    output logic [r-1:0]                sym_out,
    output logic [lenin-1:0]            codeout,
    output logic                        done,
    output logic [(1<<(K-1))*2*r-1:0]   state_out
);

    localparam int CW   = (lenout > 1) ? $clog2(lenout) : 1;
    localparam int NST  = 1 << (K-1);

    enc_state_t        state;
    logic [lenout-1:0] msg_reg;
    logic [K-2:0]      sr;
    logic [CW-1:0]     cnt;
    logic              u;
    logic [K-1:0]      w_cur;
    logic [r-1:0]      sym_cur;

    // Select the message bit addressed by the counter, MSB first
    always_comb begin
        u = 1'b0;
        for (int unsigned i = 0; i < lenout; i++) begin
            if (cnt == CW'(i)) u = msg_reg[lenout-1-i];
        end
    end

    assign w_cur = {u, sr};

    conv_sym_gen #(
        .r  (r),
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_sym (
        .w   (w_cur),
        .sym (sym_cur)
    );

    // Trellis table: one generator per (state, input) pair
    for (genvar s = 0; s < NST; s++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam logic [K-2:0] SV = s;
            localparam logic         BV = b;
            conv_sym_gen #(
                .r  (r),
                .K  (K),
                .G0 (G0),
                .G1 (G1)
            ) u_tab (
                .w   ({BV, SV}),
                .sym (state_out[(s*2+b)*r +: r])
            );
        end
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            msg_reg   <= '0;
            sr        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            sym_valid <= 1'b0;
            sym_out   <= '0;
            codeout   <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done      <= 1'b0;
                    sym_valid <= 1'b0;
                    if (start) begin
                        msg_reg <= msg_in;
                        sr      <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    sym_out   <= sym_cur;
                    sym_valid <= 1'b1;
                    for (int unsigned i = 0; i < lenout; i++) begin
                        if (cnt == CW'(i)) codeout[(lenout-i)*r-1 -: r] <= sym_cur;
                    end
                    sr  <= w_cur[K-1:1];
                    cnt <= cnt + CW'(1);
                    // busy drops with the last symbol so it spans exactly lenout cycles
                    if (cnt == CW'(lenout-1)) begin
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    sym_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Testbench for conv_encoder: directed and random frames checked against a
// convolution reference model written as tap sums over the message history.
module tb_conv_encoder;

    localparam int R      = 2;
    localparam int K      = 3;
    localparam int LENOUT = 5;
    localparam int LENIN  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LENOUT-1:0] msg_in;
    logic             busy;
    logic             sym_valid;
    logic [R-1:0]     sym_out;
    logic [LENIN-1:0] codeout;
    logic             done;
    logic [15:0]      state_out;

    int checks   = 0;
    int failures = 0;

    conv_encoder #(
        .r      (R),
        .K      (K),
        .lenout (LENOUT),
        .lenin  (LENIN),
        .G0     (3'b111),
        .G1     (3'b101)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .msg_in    (msg_in),
        .busy      (busy),
        .sym_valid (sym_valid),
        .sym_out   (sym_out),
        .codeout   (codeout),
        .done      (done),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    // Generator polynomials: index 0 -> symbol MSB, index 1 -> symbol LSB
    function automatic int gen_poly(input int j);
        return (j == 0) ? 7 : 5;
    endfunction

    // Symbol k of a message: parity of sum over d of g[K-1-d] * m[k-d]
    function automatic logic [1:0] model_sym(input logic [4:0] msg, input int k);
        logic [1:0] res;
        res = 2'b00;
        for (int j = 0; j < 2; j++) begin
            int acc;
            acc = 0;
            for (int d = 0; d < K; d++) begin
                int idx;
                int m;
                int tap;
                idx = k - d;
                m   = (idx >= 0) ? ((int'(msg) >> (LENOUT-1-idx)) & 1) : 0;
                tap = (gen_poly(j) >> (K-1-d)) & 1;
                acc = acc + m * tap;
            end
            res[1-j] = (acc % 2 == 1);
        end
        return res;
    endfunction

    function automatic logic [9:0] model_code(input logic [4:0] msg);
        int code;
        code = 0;
        for (int k = 0; k < LENOUT; k++) code = code * 4 + int'(model_sym(msg, k));
        return code[9:0];
    endfunction

    // Table entry: previous inputs come from state s (MSB most recent)
    function automatic logic [15:0] model_table();
        logic [15:0] t;
        t = '0;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 2; b++) begin
                for (int j = 0; j < 2; j++) begin
                    int acc;
                    acc = 0;
                    for (int d = 0; d < K; d++) begin
                        int m;
                        m   = (d == 0) ? b : ((s >> (K-1-d)) & 1);
                        acc = acc + m * ((gen_poly(j) >> (K-1-d)) & 1);
                    end
                    t[(s*2+b)*2 + (1-j)] = (acc % 2 == 1);
                end
            end
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ignore_at 0..4: extra start while encoding; 5: extra start in DONE
    task automatic run_frame(input logic [4:0] msg, input int ignore_at, input logic [4:0] other);
        logic [9:0] exp_code;
        exp_code = model_code(msg);
        msg_in = msg;
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("busy_e0", 32'(busy), 32'd1);
        check("symv_e0", 32'(sym_valid), 32'd0);
        check("done_e0", 32'(done), 32'd0);
        for (int k = 0; k < LENOUT; k++) begin
            if (k == ignore_at) begin
                msg_in = other;
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            check("symv", 32'(sym_valid), 32'd1);
            check("sym", 32'(sym_out), 32'(model_sym(msg, k)));
            check("busy", 32'(busy), (k < LENOUT-1) ? 32'd1 : 32'd0);
            check("done_early", 32'(done), 32'd0);
        end
        if (ignore_at == LENOUT) begin
            msg_in = other;
            start  = 1'b1;
        end
        tick();
        start = 1'b0;
        check("done", 32'(done), 32'd1);
        check("codeout", 32'(codeout), 32'(exp_code));
        check("symv_done", 32'(sym_valid), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        msg_in = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_symv", 32'(sym_valid), 32'd0);
        check("rst_sym", 32'(sym_out), 32'd0);
        check("rst_code", 32'(codeout), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("table_const", 32'(state_out), 32'h963C);
        check("table_model", 32'(state_out), 32'(model_table()));
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_code", 32'(codeout), 32'd0);

        run_frame(5'b10110, -1, 5'b0);
        check("code_385", 32'(codeout), 32'h385);

        run_frame(5'b00000, -1, 5'b0);
        check("code_000", 32'(codeout), 32'h000);
        run_frame(5'b11111, -1, 5'b0);
        check("code_36A", 32'(codeout), 32'h36A);

        run_frame(5'b10110, 2, 5'b01001);
        check("code_ign", 32'(codeout), 32'h385);
        tick();
        check("no_extra_done", 32'(done), 32'd0);
        check("no_extra_busy", 32'(busy), 32'd0);

        run_frame(5'b01101, 5, 5'b11111);
        tick();
        check("done_ign_done", 32'(done), 32'd0);
        check("done_ign_busy", 32'(busy), 32'd0);
        tick();
        check("done_ign_symv", 32'(sym_valid), 32'd0);
        check("done_ign_code", 32'(codeout), 32'(model_code(5'b01101)));

        msg_in = 5'b10110;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid_symv", 32'(sym_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_symv", 32'(sym_valid), 32'd0);
        check("arst_sym", 32'(sym_out), 32'd0);
        check("arst_code", 32'(codeout), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        run_frame(5'b10110, -1, 5'b0);
        check("code_385_rst", 32'(codeout), 32'h385);

        for (int n = 0; n < 24; n++) begin
            run_frame(5'($urandom_range(31, 0)), -1, 5'b0);
            if ($urandom_range(1, 0) == 1) tick();
        end
        check("table_final", 32'(state_out), 32'h963C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
